// File: rtl/mem_stage_vec_sequencer_if.sv
// Data-memory beat port between the MEM-stage sequencer (master) and data memory (slave).
// The request is held until it is acknowledged; read data is valid with the ack.
interface mem_stage_vec_sequencer_if #(
  parameter int N = 32
);
  logic         mem_req_o;
  logic         mem_we_o;
  logic [N-1:0] mem_addr_o;
  logic [N-1:0] mem_wdata_o;
  logic [N-1:0] mem_rdata_i;
  logic         mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_stage_vec_sequencer.sv
// MEM-stage sequencer: scalar/vector loads and stores serialised into one-beat accesses.
// Optional ack watchdog with err_o output enabled by `define MEM_SEQ_ACK_TIMEOUT_EN.
module mem_stage_vec_sequencer #(
  parameter int N       = 32,
  parameter int V       = 20,
  parameter int L       = 8,
  parameter int LPB     = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                valid_i,
  input  logic [4:0]          A3_i,
  input  logic [1:0]          OpType_i,
  input  logic                MemWE_i,
  input  logic                WBSelect_i,
  input  logic                RegFile_WE_i,
  input  logic [N-1:0]        AluResult_S_i,
  input  logic [V*L-1:0]      AluResult_V_i,
  input  logic [N-1:0]        RD2_S_i,
  input  logic [V*L-1:0]      RD2_V_i,
  mem_stage_vec_sequencer_if.master mem,
  output logic                stall_o,
  output logic                valid_o,
  output logic [4:0]          A3_o,
  output logic [1:0]          OpType_o,
  output logic                RegFile_WE_o,
  output logic                WBSelect_o,
  output logic [N-1:0]        ReadData_S_o,
  output logic [V*L-1:0]      ReadData_V_o
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
  , output logic              err_o
`endif
);

  localparam int NBEATS = V / LPB;
  localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if (N != LPB * L) begin : g_chk_beat_width
    $error("mem_stage_vec_sequencer: N must equal LPB*L");
  end
  if (V % LPB != 0) begin : g_chk_lanes
    $error("mem_stage_vec_sequencer: V must be a multiple of LPB");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("mem_stage_vec_sequencer: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [N-1:0]     r_base;
  logic [N-1:0]     r_wd_s;
  logic [V*L-1:0]   r_wd_v;
  logic             r_we;
  logic             r_vec;
  logic             r_load;
  logic             r_valid;
  logic [4:0]       r_a3;
  logic [1:0]       r_op;
  logic             r_rfwe;
  logic             r_wbsel;
  logic [N-1:0]     r_rd_s;
  logic [V*L-1:0]   r_rd_v;

  logic             w_memop;
  logic             w_busy;
  logic             w_last;
  logic [N-1:0]     w_addr;
  logic [N-1:0]     w_wdata;

  assign w_memop = valid_i & (MemWE_i | WBSelect_i);
  assign w_busy  = (r_state == S_BUSY);
  assign w_last  = r_vec ? (r_k == KW'(NBEATS - 1)) : 1'b1;
  assign w_addr  = r_base + (N'(r_k) << 2);
  assign w_wdata = r_vec ? r_wd_v[r_k*N +: N] : r_wd_s;

`ifdef MEM_SEQ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait;
  logic          r_err;
  logic          w_tmo;
  // Fires on the TIMEOUT-th consecutive unacknowledged cycle of the current beat.
  assign w_tmo = (r_wait == TW'(TIMEOUT - 1)) & ~mem.mem_ack_i;
  assign err_o = r_err;
`endif

  // Request is a pure decode of state so reset removes it without waiting for a clock.
  assign mem.mem_req_o   = w_busy;
  assign mem.mem_we_o    = w_busy & r_we;
  assign mem.mem_addr_o  = w_busy ? w_addr  : '0;
  assign mem.mem_wdata_o = w_busy ? w_wdata : '0;

  assign stall_o      = ~RST & (w_busy | ((r_state == S_IDLE) & w_memop));
  assign valid_o      = r_valid;
  assign A3_o         = r_a3;
  assign OpType_o     = r_op;
  assign RegFile_WE_o = r_rfwe;
  assign WBSelect_o   = r_wbsel;
  assign ReadData_S_o = r_rd_s;
  assign ReadData_V_o = r_rd_v;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_base  <= '0;
      r_wd_s  <= '0;
      r_wd_v  <= '0;
      r_we    <= 1'b0;
      r_vec   <= 1'b0;
      r_load  <= 1'b0;
      r_valid <= 1'b0;
      r_a3    <= '0;
      r_op    <= '0;
      r_rfwe  <= 1'b0;
      r_wbsel <= 1'b0;
      r_rd_s  <= '0;
      r_rd_v  <= '0;
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
      r_wait  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          if (valid_i) begin
            r_a3    <= A3_i;
            r_op    <= OpType_i;
            r_rfwe  <= RegFile_WE_i;
            r_wbsel <= WBSelect_i;
            r_rd_s  <= AluResult_S_i;
            r_rd_v  <= AluResult_V_i;
            if (w_memop) begin
              r_base  <= AluResult_S_i;
              r_wd_s  <= RD2_S_i;
              r_wd_v  <= RD2_V_i;
              r_we    <= MemWE_i;
              r_vec   <= OpType_i[0];
              r_load  <= WBSelect_i & ~MemWE_i;
              r_k     <= '0;
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
              r_wait  <= '0;
`endif
              r_state <= S_BUSY;
            end else begin
              r_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (mem.mem_ack_i) begin
            if (r_load) begin
              if (r_vec) r_rd_v[r_k*N +: N] <= mem.mem_rdata_i;
              else       r_rd_s             <= mem.mem_rdata_i;
            end
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
            r_wait <= '0;
`endif
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
          else if (w_tmo) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_rd_s  <= '0;
            r_rd_v  <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_valid <= 1'b0;
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_vec_sequencer.sv
// Directed bench for mem_stage_vec_sequencer: reset, non-mem, scalar load, vector store,
// address wrap, mid-access abort, and (with MEM_SEQ_ACK_TIMEOUT_EN) the ack watchdog.
module tb_mem_stage_vec_sequencer;
  localparam int N = 32;
  localparam int V = 20;
  localparam int L = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           valid_i;
  logic [4:0]     A3_i;
  logic [1:0]     OpType_i;
  logic           MemWE_i, WBSelect_i, RegFile_WE_i;
  logic [N-1:0]   AluResult_S_i, RD2_S_i;
  logic [V*L-1:0] AluResult_V_i, RD2_V_i;
  logic           stall_o, valid_o, RegFile_WE_o, WBSelect_o;
  logic [4:0]     A3_o;
  logic [1:0]     OpType_o;
  logic [N-1:0]   ReadData_S_o;
  logic [V*L-1:0] ReadData_V_o;
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
  logic           err_o;
`endif

  logic           use_model;
  logic [N-1:0]   rdata_fix;
  int             tests = 0;
  int             fails = 0;
  int             stall_cnt;

  logic [31:0] exp_wd   [5] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110};
  logic [31:0] exp_wrap [5] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004, 32'h00000008};

  always #5 CLK = ~CLK;

  mem_stage_vec_sequencer_if #(.N(N)) mif ();

  // Memory model: either a fixed word or the bitwise inverse of the beat address.
  assign mif.mem_rdata_i = use_model ? ~mif.mem_addr_o : rdata_fix;

  mem_stage_vec_sequencer dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .A3_i(A3_i), .OpType_i(OpType_i),
    .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i), .RegFile_WE_i(RegFile_WE_i),
    .AluResult_S_i(AluResult_S_i), .AluResult_V_i(AluResult_V_i),
    .RD2_S_i(RD2_S_i), .RD2_V_i(RD2_V_i), .mem(mif.master),
    .stall_o(stall_o), .valid_o(valid_o), .A3_o(A3_o), .OpType_o(OpType_o),
    .RegFile_WE_o(RegFile_WE_o), .WBSelect_o(WBSelect_o),
    .ReadData_S_o(ReadData_S_o), .ReadData_V_o(ReadData_V_o)
`ifdef MEM_SEQ_ACK_TIMEOUT_EN
    , .err_o(err_o)
`endif
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  initial begin
    valid_i = 0; A3_i = 0; OpType_i = 0; MemWE_i = 0; WBSelect_i = 0; RegFile_WE_i = 0;
    AluResult_S_i = 0; AluResult_V_i = 0; RD2_S_i = 0; RD2_V_i = 0;
    use_model = 0; rdata_fix = 0; mif.mem_ack_i = 0;
    tick; tick;
    check("rst_valid", valid_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_req", mif.mem_req_o, 0);
    check("rst_rdata_s", ReadData_S_o, 0);
    RST = 0;

    // Non-memory op
    valid_i = 1; A3_i = 5'd7; OpType_i = 2'b10; RegFile_WE_i = 1;
    AluResult_S_i = 32'h1234; AluResult_V_i = 160'hABCD;
    #1 check("nm_stall_now", stall_o, 0);
    tick;
    check("nm_valid", valid_o, 1);
    check("nm_rdata_s", ReadData_S_o, 32'h1234);
    check("nm_rdata_v", ReadData_V_o, 160'hABCD);
    check("nm_a3", A3_o, 7);
    check("nm_optype", OpType_o, 2);
    check("nm_stall", stall_o, 0);
    valid_i = 0;
    tick;
    check("nm_valid_pulse", valid_o, 0);

    // Async reset mid-cycle
    valid_i = 1; AluResult_S_i = 32'h5555; A3_i = 5'd9;
    tick;
    check("ar_valid_pre", valid_o, 1);
    #2 RST = 1; valid_i = 0;
    #1;
    check("ar_valid", valid_o, 0);
    check("ar_rdata_s", ReadData_S_o, 0);
    check("ar_a3", A3_o, 0);
    #1 RST = 0;
    tick;

    // Scalar load, ack in second BUSY cycle
    valid_i = 1; WBSelect_i = 1; MemWE_i = 0; OpType_i = 2'b00; A3_i = 5'd3; RegFile_WE_i = 1;
    AluResult_S_i = 32'h100; rdata_fix = 32'hDEADBEEF;
    #1 check("sl_stall_idle", stall_o, 1);
    tick;
    check("sl_req1", mif.mem_req_o, 1);
    check("sl_we1", mif.mem_we_o, 0);
    check("sl_addr1", mif.mem_addr_o, 32'h100);
    check("sl_valid_busy", valid_o, 0);
    tick;
    check("sl_req2", mif.mem_req_o, 1);
    check("sl_addr2", mif.mem_addr_o, 32'h100);
    mif.mem_ack_i = 1;
    tick;
    check("sl_done_valid", valid_o, 1);
    check("sl_done_data", ReadData_S_o, 32'hDEADBEEF);
    check("sl_done_stall", stall_o, 0);
    check("sl_done_req", mif.mem_req_o, 0);
    check("sl_done_wbsel", WBSelect_o, 1);
    mif.mem_ack_i = 0; valid_i = 0;
    tick;
    check("sl_after_valid", valid_o, 0);

    // Vector store, ack every cycle
    valid_i = 1; WBSelect_i = 0; MemWE_i = 1; OpType_i = 2'b01; RegFile_WE_i = 0;
    AluResult_S_i = 32'h200;
    for (int i = 0; i < V; i++) RD2_V_i[i*L +: L] = 8'(i);
    mif.mem_ack_i = 1;
    stall_cnt = 0;
    #1 if (stall_o) stall_cnt++;
    for (int b = 0; b < 5; b++) begin
      tick;
      if (stall_o) stall_cnt++;
      check($sformatf("vs_addr%0d", b), mif.mem_addr_o, 32'h200 + 32'(4 * b));
      check($sformatf("vs_wdata%0d", b), mif.mem_wdata_o, exp_wd[b]);
      check($sformatf("vs_we%0d", b), mif.mem_we_o, 1);
    end
    tick;
    if (stall_o) stall_cnt++;
    check("vs_done_valid", valid_o, 1);
    check("vs_done_rfwe", RegFile_WE_o, 0);
    valid_i = 0; mif.mem_ack_i = 0;
    tick;
    if (stall_o) stall_cnt++;
    check("vs_stall_cycles", stall_cnt, 6);

    // Vector load wrapping past 2^N
    valid_i = 1; WBSelect_i = 1; MemWE_i = 0; OpType_i = 2'b01; A3_i = 5'd9; RegFile_WE_i = 1;
    AluResult_S_i = 32'hFFFFFFF8; use_model = 1; mif.mem_ack_i = 1;
    for (int b = 0; b < 5; b++) begin
      tick;
      check($sformatf("wr_addr%0d", b), mif.mem_addr_o, exp_wrap[b]);
    end
    tick;
    check("wr_done_valid", valid_o, 1);
    check("wr_done_data", ReadData_V_o,
          {32'hFFFFFFF7, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'h00000003, 32'h00000007});
    valid_i = 0;
    tick;

    // Reset during beat 2 of a vector load
    valid_i = 1; AluResult_S_i = 32'h300;
    tick; tick; tick;
    check("ab_addr_beat2", mif.mem_addr_o, 32'h308);
    #2 RST = 1; valid_i = 0;
    #1;
    check("ab_req_async", mif.mem_req_o, 0);
    check("ab_valid", valid_o, 0);
    #1 RST = 0;
    tick;
    check("ab_valid_after", valid_o, 0);
    valid_i = 1; AluResult_S_i = 32'h400;
    tick;
    check("ab_restart_addr", mif.mem_addr_o, 32'h400);
    for (int b = 1; b < 5; b++) tick;
    tick;
    check("ab_restart_valid", valid_o, 1);
    check("ab_restart_lane0", ReadData_V_o[31:0], 32'hFFFFFBFF);
    valid_i = 0; mif.mem_ack_i = 0; use_model = 0;
    tick;

`ifdef MEM_SEQ_ACK_TIMEOUT_EN
    valid_i = 1; OpType_i = 2'b00; AluResult_S_i = 32'h500;
    tick;
    valid_i = 0;
    for (int c = 1; c < 15; c++) tick;
    check("to_req_last", mif.mem_req_o, 1);
    check("to_err_early", err_o, 0);
    tick;
    check("to_err", err_o, 1);
    check("to_valid", valid_o, 1);
    check("to_data", ReadData_S_o, 0);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
